// File: rtl/edge_stamper_pkg.sv
// Shared definitions for the edge_stamper block.
//   MODE_* : per-channel edge-selection codes (bit 0 enables rising, bit 1 falling)
//   mode_enables() : whether a given mode lets an edge of the given polarity through
package edge_stamper_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  function automatic logic mode_enables(input logic [1:0] mode, input logic is_rise);
    logic en;
    unique case (mode)
      MODE_OFF:  en = 1'b0;
      MODE_RISE: en = is_rise;
      MODE_FALL: en = !is_rise;
      default:   en = 1'b1;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/edge_stamper_ch.sv
// One edge_stamper channel: synchroniser, glitch filter, mode-gated edge strobes and a
// single-entry pending event slot.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   hit_i              : asynchronous hit level
//   mode_i             : edge selection for this channel
//   ts_i               : current coarse timestamp (captured on a qualifying edge)
//   drain_i            : top level is taking the pending slot at this edge
//   rise_o, fall_o     : registered one-cycle strobes
//   pvalid_o/ppol_o/pts_o : pending slot contents
//   drop_o             : a qualifying edge found the slot occupied and was discarded
module edge_stamper_ch
  import edge_stamper_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 0,
  parameter int unsigned TS_WIDTH    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                hit_i,
  input  logic [1:0]          mode_i,
  input  logic [TS_WIDTH-1:0] ts_i,
  input  logic                drain_i,
  output logic                rise_o,
  output logic                fall_o,
  output logic                pvalid_o,
  output logic                ppol_o,
  output logic [TS_WIDTH-1:0] pts_o,
  output logic                drop_o
);

  localparam logic [7:0] FiltMax = 8'(FILTER_LEN);

  typedef struct packed {
    logic                pol;
    logic [TS_WIDTH-1:0] ts;
  } pend_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   filt_q, filt_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   rise_q, rise_d, fall_q, fall_d;
  logic                   pvalid_q, pvalid_d;
  pend_t                  pend_q, pend_d;
  logic                   edge_gated;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // The filtered level only follows sync after FILTER_LEN+1 consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync_lvl == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == FiltMax) begin
      filt_d = sync_lvl;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // A new edge may refill a slot that is being drained at the same clock edge.
  always_comb begin
    rise_d     = (filt_d != filt_q) && filt_d && mode_enables(mode_i, 1'b1);
    fall_d     = (filt_d != filt_q) && !filt_d && mode_enables(mode_i, 1'b0);
    edge_gated = rise_d | fall_d;
    drop_o     = edge_gated && pvalid_q && !drain_i;
    pvalid_d   = pvalid_q;
    pend_d     = pend_q;
    if (edge_gated && (!pvalid_q || drain_i)) begin
      pvalid_d   = 1'b1;
      pend_d.pol = rise_d;
      pend_d.ts  = ts_i;
    end else if (drain_i) begin
      pvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      filt_q   <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      pvalid_q <= 1'b0;
      pend_q   <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], hit_i};
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pvalid_q <= pvalid_d;
      pend_q   <= pend_d;
    end
  end

  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign pvalid_o = pvalid_q;
  assign ppol_o   = pend_q.pol;
  assign pts_o    = pend_q.ts;

endmodule

// File: rtl/edge_stamper.sv
// Multi-channel hit edge stamper: per-channel filtered edge detection feeding a single
// valid/ready event stream tagged with channel, polarity and coarse timestamp.
//   iClk, iRst            : clock, synchronous active-high reset
//   iHit, iMode           : asynchronous hit levels, per-channel 2-bit mode
//   oRise, oFall          : one-cycle mode-gated strobes per channel
//   oEvtValid, iEvtReady  : event handshake
//   oEvtChan/Pol/Time     : event payload, stable while stalled
//   oOverflow, iClrOvf    : sticky drop flag and its clear (set wins)
module edge_stamper
  import edge_stamper_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 0,
  parameter int unsigned TS_WIDTH    = 16,
  localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [CHANNELS-1:0]   iHit,
  input  logic [2*CHANNELS-1:0] iMode,
  output logic [CHANNELS-1:0]   oRise,
  output logic [CHANNELS-1:0]   oFall,
  output logic                  oEvtValid,
  input  logic                  iEvtReady,
  output logic [CH_W-1:0]       oEvtChan,
  output logic                  oEvtPol,
  output logic [TS_WIDTH-1:0]   oEvtTime,
  output logic                  oOverflow,
  input  logic                  iClrOvf
);

  logic [TS_WIDTH-1:0] ts_q;
  logic [CHANNELS-1:0] pvalid, ppol, drop, drain;
  logic [TS_WIDTH-1:0] pts [CHANNELS];

  logic                sel_any, sel_pol;
  logic [CH_W-1:0]     sel_idx;
  logic [TS_WIDTH-1:0] sel_ts;
  logic                out_load;

  logic                valid_q, valid_d, pol_q, pol_d, ovf_q, ovf_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic [TS_WIDTH-1:0] time_q, time_d;

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    edge_stamper_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILTER_LEN (FILTER_LEN),
      .TS_WIDTH   (TS_WIDTH)
    ) u_ch (
      .clk_i   (iClk),
      .rst_i   (iRst),
      .hit_i   (iHit[g]),
      .mode_i  (iMode[2*g+1:2*g]),
      .ts_i    (ts_q),
      .drain_i (drain[g]),
      .rise_o  (oRise[g]),
      .fall_o  (oFall[g]),
      .pvalid_o(pvalid[g]),
      .ppol_o  (ppol[g]),
      .pts_o   (pts[g]),
      .drop_o  (drop[g])
    );
  end

  assign out_load = !valid_q || iEvtReady;

  // Descending scan so the lowest pending index wins.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    sel_pol = 1'b0;
    sel_ts  = '0;
    for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
      if (pvalid[c]) begin
        sel_any = 1'b1;
        sel_idx = CH_W'(c);
        sel_pol = ppol[c];
        sel_ts  = pts[c];
      end
    end
  end

  always_comb begin
    drain = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      drain[c] = out_load && sel_any && (sel_idx == CH_W'(c));
    end
  end

  always_comb begin
    valid_d = valid_q;
    chan_d  = chan_q;
    pol_d   = pol_q;
    time_d  = time_q;
    if (out_load) begin
      valid_d = sel_any;
      if (sel_any) begin
        chan_d = sel_idx;
        pol_d  = sel_pol;
        time_d = sel_ts;
      end
    end
    ovf_d = ovf_q;
    if (|drop) begin
      ovf_d = 1'b1;
    end else if (iClrOvf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      ts_q    <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      pol_q   <= 1'b0;
      time_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_q + 1'b1;
      valid_q <= valid_d;
      chan_q  <= chan_d;
      pol_q   <= pol_d;
      time_q  <= time_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oEvtValid = valid_q;
  assign oEvtChan  = chan_q;
  assign oEvtPol   = pol_q;
  assign oEvtTime  = time_q;
  assign oOverflow = ovf_q;

endmodule

// File: tb/tb_edge_stamper.sv
// Self-checking bench for edge_stamper: directed scenarios with hand-derived expectations,
// then randomized hits/modes/backpressure/resets checked every cycle against a
// behavioural model built from hit history windows and per-channel slots.
module tb_edge_stamper;

  localparam int unsigned CH  = 4;
  localparam int unsigned S   = 2;
  localparam int unsigned L   = 3;
  localparam int unsigned TSW = 10;
  localparam int unsigned CW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, ready, clr;
  logic [CH-1:0]   hit;
  logic [2*CH-1:0] mode;
  logic [CH-1:0]   rise, fall;
  logic            valid, pol, ovf;
  logic [CW-1:0]   chan;
  logic [TSW-1:0]  tm;

  edge_stamper #(
    .CHANNELS   (CH),
    .SYNC_STAGES(S),
    .FILTER_LEN (L),
    .TS_WIDTH   (TSW)
  ) dut (
    .iClk     (clk),
    .iRst     (rst),
    .iHit     (hit),
    .iMode    (mode),
    .oRise    (rise),
    .oFall    (fall),
    .oEvtValid(valid),
    .iEvtReady(ready),
    .oEvtChan (chan),
    .oEvtPol  (pol),
    .oEvtTime (tm),
    .oOverflow(ovf),
    .iClrOvf  (clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int             n;          // index of the next post-reset clock edge
  logic [CH-1:0]  hq[$];      // hit sampled at each post-reset edge
  logic [CH-1:0]  sq[$];      // sync level seen at each post-reset edge
  logic [CH-1:0]  fm, pv, pp;
  logic [TSW-1:0] pt [CH];
  logic [CH-1:0]  e_rise, e_fall;
  logic           e_valid, e_pol, e_ovf;
  logic [CW-1:0]  e_chan;
  logic [TSW-1:0] e_time;
  bit             started = 0;

  // Called between edges with the inputs the coming edge will sample.
  task automatic model_step();
    logic [CH-1:0]  syncv, newf, win;
    logic [TSW-1:0] tsb;
    logic           drop, alld;
    bit             found;
    int             idx;
    if (rst) begin
      n = 0;
      hq.delete();
      sq.delete();
      fm = '0; pv = '0; pp = '0;
      for (int c = 0; c < CH; c++) pt[c] = '0;
      e_rise = '0; e_fall = '0; e_valid = 0; e_pol = 0; e_ovf = 0;
      e_chan = '0; e_time = '0;
      started = 1;
    end else begin
      hq.push_back(hit);
      syncv = (n >= int'(S)) ? hq[n-S] : '0;
      sq.push_back(syncv);
      tsb = TSW'(n);
      if (!e_valid || ready) begin
        found = 0;
        for (int c = 0; c < CH; c++) begin
          if (!found && pv[c]) begin
            found = 1; e_chan = CW'(c); e_pol = pp[c]; e_time = pt[c]; pv[c] = 0;
          end
        end
        e_valid = found;
      end
      drop = 0;
      newf = fm;
      for (int c = 0; c < CH; c++) begin
        // Level accepted once the last L+1 sync samples all disagree with it.
        alld = 1;
        for (int k = 0; k <= int'(L); k++) begin
          idx = n - k;
          win = (idx >= 0) ? sq[idx] : '0;
          if (win[c] == fm[c]) alld = 0;
        end
        if (alld) newf[c] = ~fm[c];
        e_rise[c] = alld && newf[c] && mode[2*c];
        e_fall[c] = alld && !newf[c] && mode[2*c+1];
        if (e_rise[c] || e_fall[c]) begin
          if (pv[c]) drop = 1;
          else begin pv[c] = 1; pp[c] = e_rise[c]; pt[c] = tsb; end
        end
      end
      fm = newf;
      if (drop) e_ovf = 1;
      else if (clr) e_ovf = 0;
      n++;
    end
  endtask

  logic [CW+TSW:0] act_data, exp_data;
  always @(negedge clk) begin
    if (started) begin
      act_data = e_valid ? {chan, pol, tm} : '0;
      exp_data = e_valid ? {e_chan, e_pol, e_time} : '0;
      chk("cycle", {rise, fall, valid, ovf, act_data}, {e_rise, e_fall, e_valid, e_ovf, exp_data});
    end
    model_step();
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int             ev_n, nd, stall;
  logic [CW-1:0]  ev_ch [8];
  logic [TSW-1:0] ev_t [8];
  logic           ev_p [8];
  int             ev_cyc [8];
  logic           seen_fall, seen_valid;

  task automatic collect(input int cycles);
    ev_n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid && ready && ev_n < 8) begin
        ev_ch[ev_n] = chan; ev_t[ev_n] = tm; ev_p[ev_n] = pol; ev_cyc[ev_n] = i;
        ev_n++;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1; hit = '0; mode = '0; ready = 1; clr = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("reset_state", 64'({rise, fall, valid, ovf, chan, pol, tm}), 64'd0);

    // Reset released with ch2 already high: rise at edge S+L, stamped with ts 5.
    tick();
    rst = 0; hit = 4'b0100; mode = 8'hFF;
    for (int e = 0; e <= 6; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 4) chk("A_rise_early", 64'(rise), 64'd0);
      if (e == 5) chk("A_rise", 64'({rise, fall}), 64'h40);
      if (e == 6) chk("A_event", 64'({valid, chan, pol, tm, rise}), {51'd0, 1'b1, 2'd2, 1'b1, 10'd5, 4'd0});
    end

    // 3-cycle low glitch on ch2 is rejected.
    tick();
    hit[2] = 0;
    repeat (3) tick();
    hit[2] = 1;
    seen_fall = 0; seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen_fall |= fall[2];
      seen_valid |= valid;
      tick();
    end
    chk("B_glitch_fall", 64'(seen_fall), 64'd0);
    chk("B_glitch_event", 64'(seen_valid), 64'd0);

    // 4-cycle low pulse is accepted: fall then rise, 4 ticks apart.
    hit[2] = 0;
    nd = n;
    repeat (4) tick();
    hit[2] = 1;
    collect(16);
    chk("B_pulse_count", 64'(ev_n), 64'd2);
    chk("B_pulse_pols", 64'({ev_p[0], ev_p[1]}), 64'b01);
    chk("B_fall_time", 64'(ev_t[0]), 64'(TSW'(nd + S + L)));
    chk("B_rise_time", 64'(ev_t[1]), 64'(TSW'(nd + 4 + S + L)));

    // Simultaneous rises on ch0, ch1, ch3 drain lowest first on consecutive cycles.
    hit = 4'b1111;
    nd = n;
    collect(16);
    chk("C_count", 64'(ev_n), 64'd3);
    chk("C_chans", 64'({ev_ch[0], ev_ch[1], ev_ch[2]}), 64'({2'd0, 2'd1, 2'd3}));
    for (int i = 0; i < 3; i++) chk("C_time", 64'(ev_t[i]), 64'(TSW'(nd + S + L)));
    chk("C_back2back", 64'({ev_cyc[1] - ev_cyc[0], ev_cyc[2] - ev_cyc[1]}), {32'd1, 32'd1});

    // Stalled consumer: ch1 fall held, rise queued, second fall dropped.
    ready = 0;
    hit[1] = 0;
    nd = n;
    repeat (8) tick();
    hit[1] = 1;
    repeat (8) tick();
    hit[1] = 0;
    repeat (8) tick();
    @(negedge clk);
    chk("D_ovf_set", 64'({ovf, valid, chan, pol}), 64'({1'b1, 1'b1, 2'd1, 1'b0}));
    chk("D_held_time", 64'(tm), 64'(TSW'(nd + S + L)));
    repeat (3) tick();
    @(negedge clk);
    chk("D_still_held", 64'(tm), 64'(TSW'(nd + S + L)));
    tick();
    clr = 1;
    tick();
    clr = 0;
    @(negedge clk);
    chk("D_ovf_clr", 64'(ovf), 64'd0);
    ready = 1;
    repeat (6) tick();

    // Reset with an event held and a slot pending discards everything.
    ready = 0;
    hit[0] = 0; hit[3] = 0;
    repeat (8) tick();
    @(negedge clk);
    chk("E_pre_valid", 64'({valid, chan, pol}), 64'({1'b1, 2'd0, 1'b0}));
    tick();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("E_reset_out", 64'({rise, fall, valid, ovf, chan, pol, tm}), 64'd0);
    tick();
    rst = 0; ready = 1;

    // Randomized traffic, backpressure, mode changes and occasional resets.
    stall = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      rst = ($urandom_range(0, 799) == 0);
      for (int c = 0; c < CH; c++) if ($urandom_range(0, 5) == 0) hit[c] = ~hit[c];
      if (stall > 0) begin
        ready = 0;
        stall--;
      end else if ($urandom_range(0, 29) == 0) begin
        stall = $urandom_range(5, 25);
        ready = 0;
      end else begin
        ready = ($urandom_range(0, 3) != 0);
      end
      clr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 99) == 0) mode = 8'($urandom);
    end
    rst = 0;
    repeat (5) tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
